// File: rtl/clock_pkg.sv
// Shared wall-clock definitions: FSM encodings, field limits and load-value clamps,
// used by time_keeper and the upstream 24-hour setting stage.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_UNSET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  // Out-of-range set values load as zero rather than being wrapped or saturated.
  function automatic logic [4:0] clamp_hour(input logic [4:0] h);
    return (h > MAX_HOUR) ? 5'd0 : h;
  endfunction

  function automatic logic [5:0] clamp_min(input logic [5:0] m);
    return (m > MAX_MIN) ? 6'd0 : m;
  endfunction

endpackage

// File: rtl/time_keeper_sec_prescaler.sv
// Whole-second prescaler: counts 0..TICK_DIV-1 while enabled; tick is asserted
// combinationally on the terminal count so the owner can act on the same edge.
module sec_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = en && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Wall clock: loads hh:mm from the setting stage on propagate, then advances hh:mm:ss
// once per second. Optional alarm comparator is built when ALARM_EN is defined.
module time_keeper
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       propagate,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       hold,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       valid,
  output logic [1:0] state
`ifdef ALARM_EN
  ,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_arm,
  input  logic       alarm_ack,
  output logic       alarm
`endif
);

  state_t     r_state;
  logic [4:0] r_hh;
  logic [5:0] r_mm;
  logic [5:0] r_ss;
  logic       r_sec_tick;
  logic       r_day_wrap;
  logic       r_valid;

  logic       w_run;
  logic       w_pre_en;
  logic       w_pre_tick;
  logic       w_tick;
  logic       w_ss_wrap;
  logic       w_mm_wrap;
  logic       w_hh_wrap;
  logic [5:0] w_ss_nxt;
  logic [5:0] w_mm_nxt;
  logic [4:0] w_hh_nxt;

  // hold gates the prescaler directly so a tick coinciding with hold rising is dropped.
  assign w_run    = (r_state == ST_RUN);
  assign w_pre_en = w_run && !hold;

  sec_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_pre_en),
    .clr   (propagate),
    .tick  (w_pre_tick)
  );

  // A load in the same cycle as a tick takes priority and suppresses the tick.
  assign w_tick    = w_pre_tick && !propagate;

  assign w_ss_wrap = (r_ss == MAX_SEC);
  assign w_mm_wrap = (r_mm == MAX_MIN);
  assign w_hh_wrap = (r_hh == MAX_HOUR);

  assign w_ss_nxt  = w_ss_wrap ? 6'd0 : r_ss + 6'd1;
  assign w_mm_nxt  = w_ss_wrap ? (w_mm_wrap ? 6'd0 : r_mm + 6'd1) : r_mm;
  assign w_hh_nxt  = (w_ss_wrap && w_mm_wrap) ? (w_hh_wrap ? 5'd0 : r_hh + 5'd1) : r_hh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_UNSET;
      r_hh       <= 5'd0;
      r_mm       <= 6'd0;
      r_ss       <= 6'd0;
      r_sec_tick <= 1'b0;
      r_day_wrap <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_sec_tick <= w_tick;
      r_day_wrap <= w_tick && w_ss_wrap && w_mm_wrap && w_hh_wrap;
      if (propagate) begin
        r_hh    <= clamp_hour(set_hours);
        r_mm    <= clamp_min(set_minutes);
        r_ss    <= 6'd0;
        r_valid <= 1'b1;
        r_state <= hold ? ST_HOLD : ST_RUN;
      end else begin
        if (w_tick) begin
          r_ss <= w_ss_nxt;
          r_mm <= w_mm_nxt;
          r_hh <= w_hh_nxt;
        end
        // UNSET leaves only via a load; otherwise hold alone selects RUN or HOLD.
        if (r_state != ST_UNSET) begin
          r_state <= hold ? ST_HOLD : ST_RUN;
        end
      end
    end
  end

  assign hours    = r_hh;
  assign minutes  = r_mm;
  assign seconds  = r_ss;
  assign sec_tick = r_sec_tick;
  assign day_wrap = r_day_wrap;
  assign valid    = r_valid;
  assign state    = r_state;

`ifdef ALARM_EN
  logic r_alarm;
  logic w_match;

  // Match is judged on the time the tick is about to produce, i.e. landing on hh:mm:00.
  assign w_match = w_tick && w_run && w_ss_wrap &&
                   (w_mm_nxt == alarm_minutes) && (w_hh_nxt == alarm_hours);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm <= 1'b0;
    end else if (alarm_ack || !alarm_arm) begin
      r_alarm <= 1'b0;
    end else if (w_match) begin
      r_alarm <= 1'b1;
    end
  end

  assign alarm = r_alarm;
`endif

endmodule
